// File: rtl/spi_eng_pkg.sv
// spi_eng_pkg: shared state encoding, owner flags and reset values for the SPI byte engine
package spi_eng_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;
    localparam logic MOSI_RST = 1'b1;
    localparam logic [7:0] RDDATA_RST = 8'hFF;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter producing sclk rise/fall ticks and the final tick of a byte
module spi_clk_div #(
    parameter int DIV_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             last_tick
);
    logic [DIV_W-1:0] cnt;
    logic [3:0]       tog;
    logic             tick;

    // sclk idles low, so even-numbered toggles are rising edges
    assign tick      = run && cnt == '0;
    assign tick_rise = tick && !tog[0];
    assign tick_fall = tick && tog[0];
    assign last_tick = tick && tog == 4'd15;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            tog <= '0;
        end else if (load) begin
            cnt <= div;
            tog <= '0;
        end else if (tick) begin
            cnt <= div;
            tog <= tog + 4'd1;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/dma_spi_engine.sv
// dma_spi_engine: mode-0 SPI master byte engine shared by the DMA channel and Z80 port writes
module dma_spi_engine
    import spi_eng_pkg::*;
#(
    parameter int               DIV_W   = 3,
    parameter logic [DIV_W-1:0] DIV_RST = 3'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_req,
    input  logic [7:0] spi_wrdata,
    output logic [7:0] spi_rddata,
    output logic       spi_stb,
    input  logic       cpu_wr,
    input  logic       cpu_cs_wr,
    input  logic       cpu_div_wr,
    input  logic [7:0] zdata,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    state_t           state;
    logic [7:0]       shreg;
    logic             rx_bit;
    logic             owner;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_pd;
    logic             div_pv;
    logic             cs_pd;
    logic             cs_pv;
    logic             start;
    logic             tick_rise;
    logic             tick_fall;
    logic             last_tick;

    assign start = state == S_IDLE && (spi_req || cpu_wr);
    assign busy  = state != S_IDLE;

    spi_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .run       (state == S_SHIFT),
        .div       (div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .last_tick (last_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sclk       <= 1'b0;
            mosi       <= MOSI_RST;
            cs_n       <= 1'b1;
            spi_stb    <= 1'b0;
            spi_rddata <= RDDATA_RST;
            div        <= DIV_RST;
            owner      <= OWN_CPU;
            shreg      <= '0;
            rx_bit     <= 1'b0;
            cs_pv      <= 1'b0;
            cs_pd      <= 1'b1;
            div_pv     <= 1'b0;
            div_pd     <= DIV_RST;
        end else begin
            spi_stb <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    owner <= spi_req ? OWN_DMA : OWN_CPU;
                    shreg <= spi_req ? spi_wrdata : zdata;
                    mosi  <= spi_req ? spi_wrdata[7] : zdata[7];
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (tick_rise || tick_fall) sclk <= ~sclk;
                    // received bit is held aside so the outgoing LSB is not overwritten
                    if (tick_rise) rx_bit <= miso;
                    if (tick_fall) begin
                        shreg <= {shreg[6:0], rx_bit};
                        mosi  <= shreg[6];
                    end
                    if (last_tick) begin
                        spi_rddata <= {shreg[6:0], rx_bit};
                        spi_stb    <= owner == OWN_DMA;
                        mosi       <= MOSI_RST;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // cs/div writes during a byte wait until the engine returns to IDLE
            if (state != S_SHIFT) begin
                cs_n   <= cpu_cs_wr ? zdata[0] : cs_pv ? cs_pd : cs_n;
                div    <= cpu_div_wr ? zdata[DIV_W-1:0] : div_pv ? div_pd : div;
                cs_pv  <= 1'b0;
                div_pv <= 1'b0;
            end else begin
                if (cpu_cs_wr) begin
                    cs_pv <= 1'b1;
                    cs_pd <= zdata[0];
                end
                if (cpu_div_wr) begin
                    div_pv <= 1'b1;
                    div_pd <= zdata[DIV_W-1:0];
                end
            end
        end
    end
endmodule
